// File: rtl/ycrcb_pkg.sv
// ycrcb_pkg: shared widths and fixed-point coefficients for the RGB<->YCrCb blocks.
// Coefficient rows are packed {R, G, B}, magnitudes scaled by 2^6 with a per-term negate flag.
package ycrcb_pkg;
    localparam int FRAC_DEF = 6;
    localparam int CH_W     = 8;
    localparam int COEF_W   = 6;
    localparam int PROD_W   = CH_W + COEF_W;
    localparam int SUM_W    = 17;
    localparam int OUT_W    = 10;

    localparam logic [3*COEF_W-1:0] Y_MAG  = {6'd19, 6'd38, 6'd7};
    localparam logic [2:0]          Y_NEG  = 3'b000;
    localparam logic [3*COEF_W-1:0] CB_MAG = {6'd11, 6'd21, 6'd32};
    localparam logic [2:0]          CB_NEG = 3'b110;
    localparam logic [3*COEF_W-1:0] CR_MAG = {6'd32, 6'd27, 6'd5};
    localparam logic [2:0]          CR_NEG = 3'b011;

    function automatic logic signed [SUM_W-1:0] sterm(input logic [PROD_W-1:0] p, input logic neg);
        sterm = neg ? -$signed({{(SUM_W-PROD_W){1'b0}}, p}) : $signed({{(SUM_W-PROD_W){1'b0}}, p});
    endfunction
endpackage

// File: rtl/ycc_dot3.sv
// ycc_dot3: two-stage signed dot product of (r,g,b) with one coefficient row.
// Stage 1 registers unsigned products, stage 2 the signed sum; each stage has its own load enable.
module ycc_dot3 import ycrcb_pkg::*; #(
    parameter logic [3*COEF_W-1:0] MAG = Y_MAG,
    parameter logic [2:0]          NEG = Y_NEG
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en1,
    input  logic                    i_en2,
    input  logic [CH_W-1:0]         i_r,
    input  logic [CH_W-1:0]         i_g,
    input  logic [CH_W-1:0]         i_b,
    output logic signed [SUM_W-1:0] o_sum
);
    logic [PROD_W-1:0]        r_pr, r_pg, r_pb;
    logic signed [SUM_W-1:0]  r_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pr  <= '0;
            r_pg  <= '0;
            r_pb  <= '0;
            r_sum <= '0;
        end else begin
            if (i_en1) begin
                r_pr <= PROD_W'(i_r) * PROD_W'(MAG[3*COEF_W-1 -: COEF_W]);
                r_pg <= PROD_W'(i_g) * PROD_W'(MAG[2*COEF_W-1 -: COEF_W]);
                r_pb <= PROD_W'(i_b) * PROD_W'(MAG[COEF_W-1 -: COEF_W]);
            end
            if (i_en2)
                r_sum <= sterm(r_pr, NEG[2]) + sterm(r_pg, NEG[1]) + sterm(r_pb, NEG[0]);
        end
    end

    assign o_sum = r_sum;
endmodule

// File: rtl/rgb2ycrcb_pipe.sv
// rgb2ycrcb_pipe: three-stage streaming RGB -> YCrCb converter with valid/ready and sideband tag.
// Ready ripples back combinationally so bubbles collapse and a full pipe restarts without loss.
module rgb2ycrcb_pipe import ycrcb_pkg::*; #(
    parameter int TAG_W = 20,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  r,
    input  logic [CH_W-1:0]  g,
    input  logic [CH_W-1:0]  b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y,
    output logic [OUT_W-1:0] cr,
    output logic [OUT_W-1:0] cb,
    output logic [TAG_W-1:0] out_tag
);
    logic                    r_v1, r_v2, r_v3;
    logic [TAG_W-1:0]        r_t1, r_t2, r_t3;
    logic [OUT_W-1:0]        r_y, r_cr, r_cb;
    logic                    w_rdy1, w_rdy2, w_rdy3;
    logic                    w_ld1, w_ld2, w_ld3;
    logic signed [SUM_W-1:0] w_sy, w_scb, w_scr;

    assign w_rdy3 = ~r_v3 | out_ready;
    assign w_rdy2 = ~r_v2 | w_rdy3;
    assign w_rdy1 = ~r_v1 | w_rdy2;
    // Data only moves on a real transfer so held stages never see stale inputs.
    assign w_ld1  = in_valid & w_rdy1;
    assign w_ld2  = r_v1 & w_rdy2;
    assign w_ld3  = r_v2 & w_rdy3;

    ycc_dot3 #(.MAG(Y_MAG),  .NEG(Y_NEG))  u_y  (.clk(clk), .reset(reset), .i_en1(w_ld1), .i_en2(w_ld2),
                                                 .i_r(r), .i_g(g), .i_b(b), .o_sum(w_sy));
    ycc_dot3 #(.MAG(CB_MAG), .NEG(CB_NEG)) u_cb (.clk(clk), .reset(reset), .i_en1(w_ld1), .i_en2(w_ld2),
                                                 .i_r(r), .i_g(g), .i_b(b), .o_sum(w_scb));
    ycc_dot3 #(.MAG(CR_MAG), .NEG(CR_NEG)) u_cr (.clk(clk), .reset(reset), .i_en1(w_ld1), .i_en2(w_ld2),
                                                 .i_r(r), .i_g(g), .i_b(b), .o_sum(w_scr));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_t1 <= '0;
            r_t2 <= '0;
            r_t3 <= '0;
            r_y  <= '0;
            r_cr <= '0;
            r_cb <= '0;
        end else begin
            if (w_rdy1) r_v1 <= in_valid;
            if (w_rdy2) r_v2 <= r_v1;
            if (w_rdy3) r_v3 <= r_v2;
            if (w_ld1)  r_t1 <= in_tag;
            if (w_ld2)  r_t2 <= r_t1;
            if (w_ld3) begin
                r_t3 <= r_t2;
                r_y  <= OUT_W'(w_sy >>> FRAC);
                r_cb <= OUT_W'(w_scb >>> FRAC);
                r_cr <= OUT_W'(w_scr >>> FRAC);
            end
        end
    end

    assign in_ready  = w_rdy1;
    assign out_valid = r_v3;
    assign out_tag   = r_t3;
    assign y         = r_y;
    assign cr        = r_cr;
    assign cb        = r_cb;
endmodule

// File: tb/tb_rgb2ycrcb_pipe.sv
// tb_rgb2ycrcb_pipe: directed colour vectors, latency, streaming, backpressure,
// random handshake scoreboard and mid-stream reset for rgb2ycrcb_pipe.
module tb_rgb2ycrcb_pipe;
    localparam int TAG_W = 20;

    logic             clk = 1'b0, reset = 1'b1;
    logic             in_valid = 1'b0, out_ready = 1'b1;
    logic             in_ready, out_valid;
    logic [7:0]       r = '0, g = '0, b = '0;
    logic [TAG_W-1:0] in_tag = '0, out_tag;
    logic [9:0]       y, cr, cb;

    always #5 clk = ~clk;

    rgb2ycrcb_pipe #(.TAG_W(TAG_W), .FRAC(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .g(g), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .cr(cr), .cb(cb), .out_tag(out_tag)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    typedef struct {int r, g, b, y, cb, cr;} vec_t;
    typedef struct {int tag, y, cb, cr;} exp_t;
    vec_t tbl[7];

    function automatic void model(input int rr, gg, bb, output int ey, ecb, ecr);
        ey  = (19*rr + 38*gg + 7*bb) >>> 6;
        ecb = (-11*rr - 21*gg + 32*bb) >>> 6;
        ecr = (32*rr - 27*gg - 5*bb) >>> 6;
    endfunction

    task automatic send_one(input int rr, gg, bb, tg, ey, ecb, ecr, input string nm);
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        r = rr[7:0]; g = gg[7:0]; b = bb[7:0]; in_tag = tg[TAG_W-1:0];
        @(negedge clk) chk({nm, " in_ready"}, int'(in_ready), 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) chk({nm, " valid@2"}, int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, " valid@3"}, int'(out_valid), 1);
        chk({nm, " y"}, int'(y), ey);
        chk({nm, " cb"}, int'($signed(cb)), ecb);
        chk({nm, " cr"}, int'($signed(cr)), ecr);
        chk({nm, " tag"}, int'(out_tag), tg);
    endtask

    task automatic run_stream(input int n, pv, pr, stall, input string nm, output int maxrun);
        exp_t q[$];
        exp_t e;
        int k = 0, got = 0, cyc = 0, run = 0, bound = n * 10 + 50;
        int nr, ng, nb, hold_d = 0, hold_t = 0;
        logic held = 1'b0;
        maxrun = 0;
        nr = $urandom_range(0, 255); ng = $urandom_range(0, 255); nb = $urandom_range(0, 255);
        @(posedge clk); #1;
        while (got < n && cyc < bound) begin
            in_valid  = (k < n) && ($urandom_range(1, 100) <= pv);
            r = nr[7:0]; g = ng[7:0]; b = nb[7:0]; in_tag = k[TAG_W-1:0];
            out_ready = (cyc < stall) ? 1'b0 : ($urandom_range(1, 100) <= pr);
            @(negedge clk);
            if (held) begin
                chk({nm, " stall valid"}, int'(out_valid), 1);
                chk({nm, " stall data"}, int'({y, cr, cb}), hold_d);
                chk({nm, " stall tag"}, int'(out_tag), hold_t);
            end
            if (stall > 0 && cyc >= 3 && cyc < stall) chk({nm, " full in_ready"}, int'(in_ready), 0);
            if (stall > 0 && cyc == stall) chk({nm, " release in_ready"}, int'(in_ready), 1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk({nm, " unexpected output"}, int'(out_tag), -1);
                else begin
                    e = q.pop_front();
                    chk({nm, " tag"}, int'(out_tag), e.tag);
                    chk({nm, " y"}, int'(y), e.y);
                    chk({nm, " cb"}, int'($signed(cb)), e.cb);
                    chk({nm, " cr"}, int'($signed(cr)), e.cr);
                end
                got++; run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
            held   = out_valid && !out_ready;
            hold_d = int'({y, cr, cb});
            hold_t = int'(out_tag);
            if (in_valid && in_ready) begin
                model(nr, ng, nb, e.y, e.cb, e.cr);
                e.tag = k;
                q.push_back(e);
                k++;
                nr = $urandom_range(0, 255); ng = $urandom_range(0, 255); nb = $urandom_range(0, 255);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk({nm, " outputs"}, got, n);
        chk({nm, " accepted"}, k, n);
        chk({nm, " leftover"}, q.size(), 0);
    endtask

    initial begin
        int mr;
        tbl[0] = '{255, 255, 255, 255,   0,    0};
        tbl[1] = '{  0,   0,   0,   0,   0,    0};
        tbl[2] = '{255,   0,   0,  75, -44,  127};
        tbl[3] = '{  0, 255,   0, 151, -84, -108};
        tbl[4] = '{  0,   0, 255,  27, 127,  -20};
        tbl[5] = '{100, 150, 200, 140,  33,  -29};
        tbl[6] = '{ 10,  20,  30,  18,   6,   -6};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset data", int'({y, cr, cb}), 0);
        chk("reset tag", int'(out_tag), 0);

        for (int i = 0; i < 7; i++)
            send_one(tbl[i].r, tbl[i].g, tbl[i].b, 1000 + i, tbl[i].y, tbl[i].cb, tbl[i].cr,
                     $sformatf("vec%0d", i));

        run_stream(16, 100, 100, 0, "b2b", mr);
        chk("b2b consecutive", mr, 16);
        run_stream(10, 100, 100, 6, "bp", mr);
        run_stream(10000, 50, 50, 0, "rand", mr);

        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            in_tag = TAG_W'(100 + t);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mid reset out_valid", int'(out_valid), 0);
        chk("mid reset data", int'({y, cr, cb}), 0);
        chk("mid reset tag", int'(out_tag), 0);
        chk("mid reset in_ready", int'(in_ready), 1);
        send_one(255, 0, 0, 200, 75, -44, 127, "post reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
